// File: rtl/seq_sync_if.sv
// Timing/config bundle from the config manager to the sequence-clock consumers.
interface seq_sync_if;
    logic [15:0] SEQ_CLK_CYCLE;
    logic [15:0] SEQ_CLK_DIV;
    logic        SEQ_CLK_INIT;
    logic        OP_MODE;
    logic        SEQ_MODE;
    logic        REF_CLK_TICK;
    logic        SYNC;
    logic [31:0] SEQ_CLK_SYNC_TIME_NS;
    logic [15:0] WAVELENGTH_UM;

    modport master_port (
        output SEQ_CLK_CYCLE, SEQ_CLK_DIV, SEQ_CLK_INIT, OP_MODE, SEQ_MODE,
               REF_CLK_TICK, SYNC, SEQ_CLK_SYNC_TIME_NS, WAVELENGTH_UM
    );

    modport slave_port (
        input SEQ_CLK_CYCLE, SEQ_CLK_DIV, SEQ_CLK_INIT, OP_MODE, SEQ_MODE,
              REF_CLK_TICK, SYNC, SEQ_CLK_SYNC_TIME_NS, WAVELENGTH_UM
    );
endinterface

// File: rtl/seq_clk_gen.sv
// Sequence-clock generator: divides REF_CLK_TICK by the latched divider and
// steps a wrapping sequence point index, with a one-cycle strobe per new point.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | OP_MODE off or not yet armed; index and divider held at 0
// ARMED  | shadows latched by INIT, waiting for SYNC to start point 0
// RUN    | counting ref ticks, stepping SEQ_IDX every div_q ticks
module seq_clk_gen #(
    parameter bit RESYNC_IN_RUN = 1'b0
) (
    input  logic            CLK,
    input  logic            RST_N,
    seq_sync_if.slave_port  SYNC_IF,
    output logic [15:0]     SEQ_IDX,
    output logic            SEQ_TICK,
    output logic            SEQ_RUN,
    output logic            SEQ_MODE_Q
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        init_prev_q, init_prev_d;
    // INIT must be observed low after reset before a rising edge can count,
    // so an INIT left high across reset does not re-arm the block.
    logic        init_low_seen_q, init_low_seen_d;
    logic [15:0] cycle_q, cycle_d;
    logic [15:0] div_q, div_d;
    logic [15:0] div_cnt_q, div_cnt_d;
    logic [15:0] idx_q, idx_d;
    logic        tick_q, tick_d;
    logic        mode_q, mode_d;

    logic        init_rise;
    logic        sync_start;
    logic        step_end;
    logic        idx_end;
    logic [15:0] cycle_cfg;
    logic [15:0] div_cfg;

    assign init_rise  = SYNC_IF.SEQ_CLK_INIT & ~init_prev_q & init_low_seen_q;
    assign sync_start = SYNC_IF.SYNC &
                        ((state_q == S_ARMED) || (RESYNC_IN_RUN && (state_q == S_RUN)));
    assign step_end   = (div_cnt_q == (div_q - 16'd1));
    assign idx_end    = (idx_q == (cycle_q - 16'd1));
    assign cycle_cfg  = (SYNC_IF.SEQ_CLK_CYCLE == 16'd0) ? 16'd1 : SYNC_IF.SEQ_CLK_CYCLE;
    assign div_cfg    = (SYNC_IF.SEQ_CLK_DIV   == 16'd0) ? 16'd1 : SYNC_IF.SEQ_CLK_DIV;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q         <= S_IDLE;
            init_prev_q     <= 1'b0;
            init_low_seen_q <= 1'b0;
            cycle_q         <= 16'd1;
            div_q           <= 16'd1;
            div_cnt_q       <= 16'd0;
            idx_q           <= 16'd0;
            tick_q          <= 1'b0;
            mode_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            init_prev_q     <= init_prev_d;
            init_low_seen_q <= init_low_seen_d;
            cycle_q         <= cycle_d;
            div_q           <= div_d;
            div_cnt_q       <= div_cnt_d;
            idx_q           <= idx_d;
            tick_q          <= tick_d;
            mode_q          <= mode_d;
        end
    end

    // Next state: mode drop, then INIT edge, then SYNC.
    always_comb begin
        state_d = state_q;
        if (!SYNC_IF.OP_MODE) begin
            state_d = S_IDLE;
        end else if (init_rise) begin
            state_d = S_ARMED;
        end else if (sync_start) begin
            state_d = S_RUN;
        end
    end

    // Next values of index, divider count, shadows and step strobe.
    always_comb begin
        init_prev_d     = SYNC_IF.SEQ_CLK_INIT;
        init_low_seen_d = init_low_seen_q | ~SYNC_IF.SEQ_CLK_INIT;
        cycle_d         = cycle_q;
        div_d           = div_q;
        mode_d          = mode_q;
        div_cnt_d       = div_cnt_q;
        idx_d           = idx_q;
        tick_d          = 1'b0;
        if (!SYNC_IF.OP_MODE) begin
            idx_d     = 16'd0;
            div_cnt_d = 16'd0;
        end else if (init_rise) begin
            cycle_d   = cycle_cfg;
            div_d     = div_cfg;
            mode_d    = SYNC_IF.SEQ_MODE;
            idx_d     = 16'd0;
            div_cnt_d = 16'd0;
        end else if (sync_start) begin
            // Same-cycle ref tick is dropped: point 0 starts a fresh step.
            idx_d     = 16'd0;
            div_cnt_d = 16'd0;
            tick_d    = 1'b1;
        end else if (state_q == S_ARMED) begin
            idx_d     = 16'd0;
        end else if ((state_q == S_RUN) && SYNC_IF.REF_CLK_TICK) begin
            if (step_end) begin
                div_cnt_d = 16'd0;
                tick_d    = 1'b1;
                idx_d     = idx_end ? 16'd0 : (idx_q + 16'd1);
            end else begin
                div_cnt_d = div_cnt_q + 16'd1;
            end
        end
    end

    assign SEQ_IDX    = idx_q;
    assign SEQ_TICK   = tick_q;
    assign SEQ_RUN    = (state_q == S_RUN);
    assign SEQ_MODE_Q = mode_q;

endmodule
